// File: rtl/mac_accum.sv
// ---------------------------------------------------------------------------
// mac_accum
//
// Accumulation stage that sits behind the multi multiplier. It sums a frame of
// unsigned products (the frame ends with the in_last beat) into a wide
// accumulator, then presents the sum, the number of terms and an overflow flag
// on a valid/ready output until the consumer takes them.
//
// Parameters
//   IN_DATA_WIDTH  product width (matches multi OUT_DATA_WIDTH)
//   ACC_WIDTH      accumulator / result width, must be >= IN_DATA_WIDTH
//   LEN_WIDTH      term counter width
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   product beat valid
//   in_ready   out  stage can accept a beat (decoded from state only)
//   in_data    in   unsigned product
//   in_last    in   beat is the final term of the frame
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  accumulated sum
//   out_count  out  number of terms in the frame (saturating)
//   out_ovf    out  sum exceeded ACC_WIDTH somewhere in the frame
//
// Build option
//   MAC_ACCUM_SAT_EN  when defined, the accumulator clamps to all-ones on the
//                     first carry out and stays clamped for the rest of the
//                     frame. When undefined, it wraps and out_ovf is sticky.
// ---------------------------------------------------------------------------
module mac_accum #(
   parameter int IN_DATA_WIDTH = 64,
   parameter int ACC_WIDTH     = 72,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_DATA_WIDTH-1:0] in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_WIDTH-1:0]     out_data,
   output logic [LEN_WIDTH-1:0]     out_count,
   output logic                     out_ovf
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [LEN_WIDTH-1:0] count;
   logic [LEN_WIDTH-1:0] count_next;
   logic                 ovf;
   logic                 ovf_next;

   logic                 beat;
   logic [ACC_WIDTH-1:0] in_ext;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;

   // The product is zero-extended and added with one extra bit so the carry
   // out of the accumulator's top bit is visible for overflow tracking.
   assign in_ext = ACC_WIDTH'(in_data);
   assign sum    = {1'b0, acc} + {1'b0, in_ext};
   assign carry  = sum[ACC_WIDTH];
   assign beat   = in_valid && in_ready;

   // State register. Reset drops any partial frame and returns to IDLE at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. in_ready and out_valid depend only on
   // the state register, so the upstream multiplier never sees a combinational
   // path from its own valid back to its ready. HOLD blocks new beats, which
   // is why the result transfer and the next frame's first beat never share a
   // cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = in_last ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Accumulator update for one accepted beat. The first beat of a frame
   // (taken in IDLE) reloads everything rather than adding, so no separate
   // clear cycle is needed between frames. The term counter sticks at its
   // maximum while the sum keeps accumulating. Once a frame has overflowed in
   // saturating mode, the stored ovf keeps the accumulator pinned at all-ones
   // even if later terms are zero.
   always_comb begin
      acc_next   = acc;
      count_next = count;
      ovf_next   = ovf;
      if (beat) begin
         if (state == IDLE) begin
            acc_next   = in_ext;
            count_next = LEN_WIDTH'(1);
            ovf_next   = 1'b0;
         end else begin
            ovf_next = ovf | carry;
`ifdef MAC_ACCUM_SAT_EN
            acc_next = (ovf | carry) ? '1 : sum[ACC_WIDTH-1:0];
`else
            acc_next = sum[ACC_WIDTH-1:0];
`endif
            if (count != '1) begin
               count_next = count + LEN_WIDTH'(1);
            end
         end
      end
   end

   // Working accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         acc   <= acc_next;
         count <= count_next;
         ovf   <= ovf_next;
      end
   end

   // Result registers. They load only on the edge where the last beat is
   // taken, i.e. on entry to HOLD, so the result is stable for as long as the
   // consumer stalls and out_valid rises the cycle after the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (beat && in_last) begin
         out_data  <= acc_next;
         out_count <= count_next;
         out_ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_mac_accum
//
// Self-checking bench for mac_accum, built with ACC_WIDTH = 64 so that
// overflow is easy to provoke. The reference model keeps the exact frame sum
// in 128 bits and the plain number of terms. It derives the expected result
// from those numbers when the last beat is taken and queues it. A negedge
// monitor compares out_valid/in_ready against whether a result is owed, and
// compares the result fields every cycle the result is shown.
// Honours MAC_ACCUM_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mac_accum;

   localparam int IW = 64;
   localparam int AW = 64;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [LW-1:0] out_count;
   logic          out_ovf;

   typedef struct {
      logic [AW-1:0] data;
      logic [LW-1:0] count;
      logic          ovf;
   } result_t;

   result_t      exp_q[$];
   logic [127:0] frame_sum;
   int           frame_len;
   int           num_checks = 0;
   int           num_fail   = 0;
   bit           mon_en     = 1'b0;
   bit           rand_ready = 1'b0;

   mac_accum #(
      .IN_DATA_WIDTH(IW),
      .ACC_WIDTH    (AW),
      .LEN_WIDTH    (LW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_ovf  (out_ovf)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Advance one cycle; inputs change 1 unit after the rising edge. In the
   // randomized phase the consumer stalls about a quarter of the time.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (rand_ready) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) stepCycle();
   endtask

   // Reference model: the frame result follows from the exact sum and the
   // number of terms. Any overshoot of 2^64 means an overflow happened.
   function automatic void modelBeat(input logic [IW-1:0] d, input logic last);
      result_t r;
      frame_sum = frame_sum + 128'(d);
      frame_len++;
      if (last) begin
         r.ovf   = (frame_sum[127:64] != '0);
         r.count = (frame_len > 255) ? 8'd255 : 8'(frame_len);
`ifdef MAC_ACCUM_SAT_EN
         r.data  = r.ovf ? '1 : frame_sum[63:0];
`else
         r.data  = frame_sum[63:0];
`endif
         exp_q.push_back(r);
         frame_sum = '0;
         frame_len = 0;
      end
   endfunction

   // Offer one beat and keep it offered until taken (bounded). waits returns
   // the number of cycles the beat was refused.
   task automatic applyStimulus(input logic [IW-1:0] d, input logic last, output int waits);
      bit accepted;
      accepted = 1'b0;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!accepted && waits < 200) begin
         @(negedge clk);
         accepted = (in_ready === 1'b1);
         stepCycle();
         if (!accepted) waits++;
      end
      if (accepted) begin
         modelBeat(d, last);
      end else begin
         checkOutput("accept_timeout", 64'(0), 64'(1));
      end
   endtask

   // Monitor: a result is owed exactly while the model queue is non-empty.
   // Checking the fields on every owed cycle also shows they stay stable
   // under backpressure.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
         if (exp_q.size() != 0) begin
            checkOutput("out_data", out_data, exp_q[0].data);
            checkOutput("out_count", 64'(out_count), 64'(exp_q[0].count));
            checkOutput("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
            if (out_ready) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Directed sequences first, then randomized frames with random bubbles
   // and random consumer stalls.
   initial begin
      int            w;
      int            len;
      logic [IW-1:0] d;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      frame_sum = '0;
      frame_len = 0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_out_data", out_data, 64'(0));
      checkOutput("rst_out_count", 64'(out_count), 64'(0));
      checkOutput("rst_out_ovf", 64'(out_ovf), 64'(0));
      checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
      rst_n     = 1'b1;
      mon_en    = 1'b1;
      out_ready = 1'b1;
      stepCycle();

      $display("[TB] basic frame");
      applyStimulus(64'd150, 1'b0, w);
      applyStimulus(64'd20, 1'b0, w);
      applyStimulus(64'd30, 1'b1, w);
      idle(2);

      $display("[TB] single-term frame");
      applyStimulus(64'd5, 1'b1, w);
      idle(2);

      $display("[TB] input bubbles");
      applyStimulus(64'd1, 1'b0, w);
      idle(3);
      applyStimulus(64'd2, 1'b0, w);
      idle(1);
      applyStimulus(64'd3, 1'b1, w);
      idle(2);

      $display("[TB] overflow");
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      applyStimulus(64'd2, 1'b1, w);
      idle(2);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(64'd40, 1'b0, w);
      applyStimulus(64'd2, 1'b1, w);
      in_valid = 1'b1;
      in_data  = 64'd9;
      in_last  = 1'b1;
      repeat (4) stepCycle();
      out_ready = 1'b1;
      applyStimulus(64'd9, 1'b1, w);
      checkOutput("bp_accept_delay", 64'(w), 64'(1));
      idle(2);

      $display("[TB] reset mid-frame");
      applyStimulus(64'd100, 1'b0, w);
      applyStimulus(64'd200, 1'b0, w);
      in_valid = 1'b0;
      in_last  = 1'b0;
      mon_en   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("mid_rst_out_data", out_data, 64'(0));
      checkOutput("mid_rst_out_count", 64'(out_count), 64'(0));
      checkOutput("mid_rst_out_ovf", 64'(out_ovf), 64'(0));
      checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = 64'd55;
      in_last  = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("in_rst_no_xfer", 64'(out_valid), 64'(0));
      in_valid  = 1'b0;
      in_last   = 1'b0;
      rst_n     = 1'b1;
      frame_sum = '0;
      frame_len = 0;
      mon_en    = 1'b1;
      stepCycle();
      applyStimulus(64'd7, 1'b1, w);
      idle(2);

      $display("[TB] count saturation");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(64'd3, (i == 299), w);
      end
      idle(2);

      $display("[TB] randomized frames");
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0) d = {$urandom, $urandom};
            else d = 64'($urandom_range(0, 1000));
            applyStimulus(d, (j == len - 1), w);
         end
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) stepCycle();
      checkOutput("drain", 64'(exp_q.size()), 64'(0));
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule

// File: doc/mac_accum.md
# mac_accum

Accumulation stage that sits directly downstream of the `multi` multiplier and consumes its product stream. It sums a frame of unsigned products, with the frame terminated by `in_last`, into a wide accumulator. It then presents the sum, term count and overflow flag on a valid/ready output until the consumer takes them. Together, `multi` and `mac_accum` form the team's dot-product / MAC datapath.

## Interface
- `IN_DATA_WIDTH`, default 64: product width; matches `multi` `OUT_DATA_WIDTH`.
- `ACC_WIDTH`, default 72: accumulator and result width; must be >= `IN_DATA_WIDTH`.
- `LEN_WIDTH`, default 8: term-counter width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  `IN_DATA_WIDTH`  unsigned product (`multi.c`).
- `in_last`  in  1  beat is the final term of the frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  `ACC_WIDTH`  accumulated sum.
- `out_count`  out  `LEN_WIDTH`  number of terms in frame.
- `out_ovf`  out  1  sum exceeded `ACC_WIDTH` at some point in the frame.

## Operation
- Beat transfer: `in_valid && in_ready` at a rising edge. Result transfer: `out_valid && out_ready` at a rising edge.
- The FSM has three states: IDLE, ACCUM and HOLD. The reset state is IDLE.
- IDLE:
  - `in_ready=1`.
  - On a beat: acc = zero-extended `in_data`, count = 1, ovf = 0.
  - Go to HOLD if `in_last`, else go to ACCUM.
- ACCUM:
  - `in_ready=1`.
  - On a beat: acc = acc + `in_data` (ACC_WIDTH+1-bit add), count += 1.
  - ovf |= carry out of bit `ACC_WIDTH-1`.
  - Go to HOLD if `in_last`.
  - Cycles with `in_valid=0` leave the state unchanged.
- HOLD:
  - `in_ready=0` and `out_valid=1`.
  - `out_data`, `out_count` and `out_ovf` are held stable.
  - On a result transfer, go to IDLE.
- Arithmetic is unsigned only. `in_data` is zero-extended to `ACC_WIDTH`.
- Count saturates at 2^LEN_WIDTH−1; the accumulation itself continues.
- Overflow handling is set by `MAC_ACCUM_SAT_EN` (see Configuration).
- `in_last` is ignored when `in_valid=0`.
- Reset mid-frame: the partial sum is discarded and the FSM returns to IDLE immediately. The frame is not resumed after reset.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_count=0`, `out_ovf=0`.
  - `in_ready=1` (IDLE). No transfer can occur while `rst_n=0`.
- Latency: `out_valid` rises in the cycle after the `in_last` beat transfers.
- Throughput: one beat per cycle within a frame. An N-term frame takes N cycles plus at least one HOLD cycle.
- The HOLD→IDLE result transfer and the first beat of the next frame cannot share a cycle. The next beat is accepted one cycle after the result transfer.
- `in_ready` is a combinational decode of the state register only; it does not depend on `in_valid`.
- Output registers update only on state entry into HOLD. The data path to the output registers is registered.

## Configuration
- Macro: `MAC_ACCUM_SAT_EN`.
- Defined: on a carry out, acc clamps to all-ones and stays clamped for the rest of the frame; `out_ovf=1`.
- Undefined: acc wraps modulo 2^ACC_WIDTH; `out_ovf` is a sticky flag set on any carry out within the frame.

## Test plan
- Basic frame: beats 150 (10×15 from `multi`), 20, 30(last), back-to-back, `out_ready=1`. Required:
  - `out_valid` high the cycle after the last beat.
  - `out_data=200`, `out_count=3`, `out_ovf=0`.
- Single-term frame: beat 5 with `in_last`. Required: `out_data=5`, `out_count=1`; then IDLE.
- Backpressure: hold `out_ready=0` for 4 cycles with `in_valid=1` pending. Required:
  - Outputs stay stable and `in_ready=0`; no beat is consumed.
  - After `out_ready=1`, the pending beat is accepted one cycle after the result transfer.
- Input bubbles: beats 1, idle ×3, 2, idle, 3(last). Required: `out_data=6`, `out_count=3`.
- Overflow, with `ACC_WIDTH=64`: beats 64'hFFFF_FFFF_FFFF_FFFF, then 2(last). Required:
  - Without the macro: `out_data=1`, `out_ovf=1`.
  - With `MAC_ACCUM_SAT_EN`: `out_data` all-ones, `out_ovf=1`.
- Reset mid-frame: beats 100, 200, then pulse `rst_n=0` asynchronously. Required:
  - Outputs return to reset values immediately.
  - A following frame 7(last) yields `out_data=7`, `out_count=1`.
